mul_sched: RTL and testbench

MUL_SCHED -- requirements
Module: mul_sched

---
 rtl/mul_sched_pkg.sv | 16 +
 rtl/mul_seq.sv | 79 +++++++
 rtl/mul_sched.sv | 139 +++++++++++++
 tb/tb_mul_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the two-requester multiply scheduler.
package mul_sched_pkg;

    // Default operand width; product width is twice this.
    localparam int unsigned WDefault = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Identifies requester 0 or requester 1.
    typedef logic req_id_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add unsigned multiplier. The first partial product is folded
// into the start cycle, so finish pulses exactly W cycles after start with res valid.
module mul_seq
    import mul_sched_pkg::*;
#(
    parameter int unsigned W = WDefault
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] res,
    output logic           finish
);

    localparam int unsigned CntW = $clog2(W + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(W - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(1);

    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            active_q, active_d;
    logic            finish_q, finish_d;

    // Next-state: load plus first add on start, then one add-shift per cycle.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        finish_d = 1'b0;
        if (start) begin
            acc_d    = b[0] ? {{W{1'b0}}, a} : '0;
            mcand_d  = {{W{1'b0}}, a} << 1;
            mplier_d = b >> 1;
            cnt_d    = CntInit;
            active_d = (W > 1);
            finish_d = (W == 1);
        end else if (active_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CntLast) begin
                active_d = 1'b0;
                finish_d = 1'b1;
            end
        end
    end

    // Datapath and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            finish_q <= finish_d;
        end
    end

    assign res    = acc_q;
    assign finish = finish_q;

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one iterative multiplier between two requesters.
// All outputs come straight from registers.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned W = WDefault
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic           req1,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           ack0,
    output logic           ack1,
    output logic           done,
    output logic           done_id,
    output logic [2*W-1:0] res,
    output logic           busy
);

    state_e         state_q, state_d;
    req_id_t        last_q, last_d;   // last granted requester
    req_id_t        owner_q, owner_d;
    req_id_t        grant;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic           start_q, start_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           done_q, done_d;
    logic           done_id_q, done_id_d;
    logic [2*W-1:0] res_q, res_d;
    logic           busy_q, busy_d;
    logic [2*W-1:0] mul_res;
    logic           mul_finish;

    mul_seq #(
        .W (W)
    ) u_mul_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (start_q),
        .a      (op_a_q),
        .b      (op_b_q),
        .res    (mul_res),
        .finish (mul_finish)
    );

    // Round-robin pick: on a tie favour whoever was not granted last.
    always_comb begin
        grant = (req0 && req1) ? ~last_q : req1;
    end

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        start_d   = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = 1'b0;
        res_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    owner_d = grant;
                    last_d  = grant;
                    op_a_d  = grant ? a1 : a0;
                    op_b_d  = grant ? b1 : b0;
                    ack0_d  = ~grant;
                    ack1_d  = grant;
                    start_d = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (mul_finish) begin
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    res_d     = mul_res;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset leaves requester 0 favoured on a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            start_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            res_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            start_q   <= start_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign res     = res_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: a transaction-timeline reference model
// predicts every output for every cycle; directed scenarios plus random traffic.
module tb_mul_sched;

    localparam int W    = 4;
    localparam int NCYC = 2048;

    logic           clk;
    logic           rst;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           ack0, ack1, done, done_id, busy;
    logic [2*W-1:0] res;

    mul_sched #(
        .W (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .ack0    (ack0),
        .ack1    (ack1),
        .done    (done),
        .done_id (done_id),
        .res     (res),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs indexed by cycle number.
    bit           e_ack0 [NCYC];
    bit           e_ack1 [NCYC];
    bit           e_done [NCYC];
    bit           e_id   [NCYC];
    bit [2*W-1:0] e_res  [NCYC];
    bit           e_busy [NCYC];

    int cyc = 0;
    int free_at = 0;   // first cycle in which a request may be accepted
    bit last_m = 1'b1; // last granted requester

    int checks = 0;
    int errors = 0;
    int ack_cyc = -1;
    int done_cyc = -1;
    bit auto_drop = 1'b1;

    // Reference model: a request accepted in cycle T is acked in T+1, its
    // product appears in T+2+W, and the next acceptance is possible at T+W+3.
    always @(posedge clk) begin
        bit           w;
        bit [2*W-1:0] xa, xb;
        if (rst) begin
            for (int i = cyc + 1; i < NCYC; i++) begin
                e_ack0[i] = 0; e_ack1[i] = 0; e_done[i] = 0;
                e_id[i] = 0; e_res[i] = '0; e_busy[i] = 0;
            end
            free_at = cyc + 1;
            last_m  = 1'b1;
        end else if (cyc >= free_at && (req0 || req1) && cyc + W + 3 < NCYC) begin
            w = (req0 && req1) ? !last_m : req1;
            last_m = w;
            xa = w ? {4'd0, a1} : {4'd0, a0};
            xb = w ? {4'd0, b1} : {4'd0, b0};
            if (w) e_ack1[cyc + 1] = 1; else e_ack0[cyc + 1] = 1;
            e_done[cyc + 2 + W] = 1;
            e_id[cyc + 2 + W]   = w;
            e_res[cyc + 2 + W]  = xa * xb;
            for (int i = cyc + 1; i <= cyc + 2 + W; i++) e_busy[i] = 1;
            free_at = cyc + W + 3;
        end
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle, compare all outputs against the model, then react.
    task automatic tick();
        @(negedge clk);
        if (cyc >= 1 && cyc < NCYC) begin
            chk("ack0", {31'd0, ack0}, {31'd0, e_ack0[cyc]});
            chk("ack1", {31'd0, ack1}, {31'd0, e_ack1[cyc]});
            chk("done", {31'd0, done}, {31'd0, e_done[cyc]});
            chk("done_id", {31'd0, done_id}, {31'd0, e_id[cyc]});
            chk("res", {24'd0, res}, {24'd0, e_res[cyc]});
            chk("busy", {31'd0, busy}, {31'd0, e_busy[cyc]});
        end
        if (ack0 === 1'b1 || ack1 === 1'b1) ack_cyc = cyc;
        if (done === 1'b1) done_cyc = cyc;
        if (auto_drop) begin
            if (ack0 === 1'b1) req0 = 1'b0;
            if (ack1 === 1'b1) req1 = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_ack();
        bit seen;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("ack_timeout", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int prev_done;
        rst = 1'b1;
        req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick();
        tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // Single requester 0: 3*5.
        req0 = 1; a0 = 4'd3; b0 = 4'd5;
        wait_done();
        chk("r022_res", {24'd0, res}, 32'd15);
        chk("r022_id", {31'd0, done_id}, 32'd0);
        chk("r022_lat", done_cyc - ack_cyc, W + 1);

        // Tie right after reset: requester 0 first, then 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1; a0 = 4'd15; b0 = 4'd15;
        req1 = 1; a1 = 4'd2;  b1 = 4'd7;
        wait_done();
        chk("r023_res0", {24'd0, res}, 32'd225);
        chk("r023_id0", {31'd0, done_id}, 32'd0);
        wait_done();
        chk("r023_res1", {24'd0, res}, 32'd14);
        chk("r023_id1", {31'd0, done_id}, 32'd1);

        // Both held continuously: grants alternate, one result per W+3 cycles.
        auto_drop = 1'b0;
        req0 = 1; a0 = 4'd1; b0 = 4'd2;
        req1 = 1; a1 = 4'd3; b1 = 4'd4;
        prev_done = -1;
        for (int k = 0; k < 4; k++) begin
            wait_done();
            chk("r024_id", {31'd0, done_id}, k % 2);
            if (prev_done >= 0) chk("r024_period", done_cyc - prev_done, W + 3);
            prev_done = done_cyc;
        end
        req0 = 0; req1 = 0;
        auto_drop = 1'b1;
        tick();

        // Reset during RUN discards the product.
        req0 = 1; a0 = 4'd5; b0 = 4'd5;
        wait_ack();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r025_busy", {31'd0, busy}, 32'd0);
        chk("r025_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("r025_nodone", {31'd0, done}, 32'd0);
        end
        req1 = 1; a1 = 4'd4; b1 = 4'd4;
        wait_done();
        chk("r025_res", {24'd0, res}, 32'd16);
        chk("r025_id", {31'd0, done_id}, 32'd1);

        // Zero operand, input changed after capture.
        req0 = 1; a0 = 4'd0; b0 = 4'd9;
        wait_ack();
        a0 = 4'd7;
        wait_done();
        chk("r026_res", {24'd0, res}, 32'd0);
        chk("r026_lat", done_cyc - ack_cyc, W + 1);

        // Random traffic with operand churn and occasional resets.
        for (int n = 0; n < 500; n++) begin
            if (!req0 && $urandom_range(0, 3) == 0) req0 = 1;
            if (!req1 && $urandom_range(0, 3) == 0) req1 = 1;
            if ($urandom_range(0, 1) == 1) begin a0 = 4'($urandom); b0 = 4'($urandom); end
            if ($urandom_range(0, 1) == 1) begin a1 = 4'($urandom); b1 = 4'($urandom); end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        req0 = 0; req1 = 0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
